// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM
// encoding and the claim-word helper.
package intr_ctrl_pkg;

    localparam logic [3:0] OFF_PENDING     = 4'h0;
    localparam logic [3:0] OFF_MASK        = 4'h4;
    localparam logic [3:0] OFF_CLAIM       = 4'h8;
    localparam int         CLAIM_VALID_BIT = 31;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ASSERTED   = 2'd1,
        IN_SERVICE = 2'd2
    } state_e;

    // Bit 31 flags a real claim so software can tell it apart from "nothing pending".
    function automatic logic [31:0] claim_word(input logic [4:0] id);
        logic [31:0] w;
        w                  = {27'd0, id};
        w[CLAIM_VALID_BIT] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-first priority encoder; index 0 is the highest priority.
module intr_prio_enc #(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] vec,
    output logic             any,
    output logic [4:0]       idx
);

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        any = |vec;
        idx = 5'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            idx = vec[i] ? 5'(i) : idx;
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Memory-mapped interrupt controller: edge-detected pending bits, mask,
// priority select and claim/EOI handshake. Define INTR_NEST_EN for nesting.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int          N_SRC     = 4,
    parameter logic [31:0] BASE_ADDR = 32'hffff0010
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src,
    input  logic [31:0]      address,
    input  logic [31:0]      wdata,
    input  logic             MemRead,
    input  logic             MemWrite,
    output logic [31:0]      rdata,
    output logic             addr_hit,
    output logic             irq
);

    localparam logic [N_SRC-1:0] ONE_S  = N_SRC'(1'b1);
    localparam logic [N_SRC-1:0] ZERO_S = {N_SRC{1'b0}};

    logic [N_SRC-1:0] pending_r;
    logic [N_SRC-1:0] mask_r;
    logic [N_SRC-1:0] src_prev_r;
    state_e           state_r;
    logic             irq_r;

    logic [31:0]      off_s;
    logic [3:0]       word_s;
    logic             rd_en_s;
    logic             wr_en_s;
    logic [N_SRC-1:0] active_s;
    logic [N_SRC-1:0] rise_s;
    logic [N_SRC-1:0] clr_s;
    logic [N_SRC-1:0] claim_clr_s;
    logic             any_s;
    logic [4:0]       sel_s;
    logic             eligible_s;
    logic             claim_s;
    logic             eoi_s;
    logic [31:0]      rdata_s;

    // Unsigned wrap makes addresses below the base fall outside the window too.
    assign off_s    = address - BASE_ADDR;
    assign addr_hit = (off_s < 32'd12);
    assign word_s   = {off_s[3:2], 2'b00};
    assign rd_en_s  = MemRead & addr_hit;
    assign wr_en_s  = MemWrite & addr_hit;

    assign active_s = pending_r & mask_r;
    assign rise_s   = src & ~src_prev_r;
    assign clr_s    = (wr_en_s && (word_s == OFF_PENDING)) ? wdata[N_SRC-1:0] : ZERO_S;

    intr_prio_enc #(.N_SRC(N_SRC)) u_sel_enc (
        .vec (active_s),
        .any (any_s),
        .idx (sel_s)
    );

`ifdef INTR_NEST_EN
    logic [N_SRC-1:0] in_service_r;
    logic [N_SRC-1:0] in_service_n_s;
    logic [N_SRC-1:0] eoi_clr_s;
    logic             svc_any_s;
    logic [4:0]       svc_idx_s;

    intr_prio_enc #(.N_SRC(N_SRC)) u_svc_enc (
        .vec (in_service_r),
        .any (svc_any_s),
        .idx (svc_idx_s)
    );

    // Only a strictly higher-priority source may preempt the running handlers.
    assign eligible_s     = any_s & (~svc_any_s | (sel_s < svc_idx_s));
    assign eoi_clr_s      = eoi_s ? (ONE_S << wdata[4:0]) : ZERO_S;
    assign in_service_n_s = (in_service_r | claim_clr_s) & ~eoi_clr_s;
`else
    logic [4:0] in_service_id_r;

    assign eligible_s = any_s;
`endif

    assign claim_s     = rd_en_s && (word_s == OFF_CLAIM) && (state_r == ASSERTED) && eligible_s;
    assign eoi_s       = wr_en_s && (word_s == OFF_CLAIM);
    assign claim_clr_s = claim_s ? (ONE_S << sel_s) : ZERO_S;

    // Read mux; a read alongside a write sees the pre-write register value.
    always_comb begin
        rdata_s = 32'd0;
        if (reset) begin
            rdata_s = 32'd0;
        end else if (rd_en_s) begin
            case (word_s)
                OFF_PENDING: rdata_s = 32'(pending_r);
                OFF_MASK:    rdata_s = 32'(mask_r);
                OFF_CLAIM:   rdata_s = claim_s ? claim_word(sel_s) : 32'd0;
                default:     rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign rdata = rdata_s;
    assign irq   = irq_r;

    // Edge capture, pending (set beats clear) and mask registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r  <= ZERO_S;
            mask_r     <= ZERO_S;
            src_prev_r <= ZERO_S;
        end else begin
            src_prev_r <= src;
            pending_r  <= (pending_r & ~clr_s & ~claim_clr_s) | rise_s;
            if (wr_en_s && (word_s == OFF_MASK)) begin
                mask_r <= wdata[N_SRC-1:0];
            end else begin
                mask_r <= mask_r;
            end
        end
    end

`ifdef INTR_NEST_EN
    // Handshake FSM with a stack of in-service sources; irq mirrors ASSERTED.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            irq_r        <= 1'b0;
            in_service_r <= ZERO_S;
        end else begin
            in_service_r <= in_service_n_s;
            case (state_r)
                IDLE: begin
                    state_r <= eligible_s ? ASSERTED : IDLE;
                    irq_r   <= eligible_s;
                end
                ASSERTED: begin
                    if (claim_s) begin
                        state_r <= IN_SERVICE;
                        irq_r   <= 1'b0;
                    end else if (!eligible_s) begin
                        state_r <= (in_service_n_s == ZERO_S) ? IDLE : IN_SERVICE;
                        irq_r   <= 1'b0;
                    end else begin
                        state_r <= ASSERTED;
                        irq_r   <= 1'b1;
                    end
                end
                IN_SERVICE: begin
                    if (in_service_n_s == ZERO_S) begin
                        state_r <= IDLE;
                        irq_r   <= 1'b0;
                    end else if (eligible_s) begin
                        state_r <= ASSERTED;
                        irq_r   <= 1'b1;
                    end else begin
                        state_r <= IN_SERVICE;
                        irq_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    irq_r   <= 1'b0;
                end
            endcase
        end
    end
`else
    // Single-level handshake FSM; irq mirrors ASSERTED.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= IDLE;
            irq_r           <= 1'b0;
            in_service_id_r <= 5'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= any_s ? ASSERTED : IDLE;
                    irq_r   <= any_s;
                end
                ASSERTED: begin
                    if (claim_s) begin
                        state_r         <= IN_SERVICE;
                        irq_r           <= 1'b0;
                        in_service_id_r <= sel_s;
                    end else if (!any_s) begin
                        state_r <= IDLE;
                        irq_r   <= 1'b0;
                    end else begin
                        state_r <= ASSERTED;
                        irq_r   <= 1'b1;
                    end
                end
                IN_SERVICE: begin
                    irq_r <= 1'b0;
                    if (eoi_s && (wdata[4:0] == in_service_id_r)) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= IN_SERVICE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    irq_r   <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
Memory-mapped interrupt controller that sits between the peripheral interrupt sources (timer and others) and the cp0 interrupt input.
- Edge-detects each source into a pending register and applies a software mask.
- Priority-selects one source and drives a single irq line to cp0.
- Runs a claim / end-of-interrupt (EOI) handshake so the handler learns the source ID and re-arms the controller.
- Decodes its own address window like the timer; the datapath gates data_mem with ~addr_hit.

Parameters:
N_SRC, 4, number of interrupt sources (1..31); source 0 is highest priority.
BASE_ADDR, 32'hffff0010, byte address of the first register; window is 3 words.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
src  in  N_SRC  raw interrupt source levels
address  in  32  byte address from the ALU output
wdata  in  32  store data (rt value)
MemRead  in  1  load strobe
MemWrite  in  1  store strobe
rdata  out  32  load data; valid in the same cycle (combinational)
addr_hit  out  1  address is in [BASE_ADDR, BASE_ADDR+8]; combinational
irq  out  1  registered interrupt request to cp0

Behaviour:
- Register map, word-aligned (address[1:0] ignored):
  - PENDING at +0: read returns pending; write-1-to-clear.
  - MASK at +4: read/write; 1 = enabled.
  - CLAIM at +8: read = claim; write = EOI.
- Reset (async): pending=0, mask=0, src_prev=0, state=IDLE, irq=0, in_service_id=0. rdata reads 0 while reset is high.
- Edge detect: src_prev<=src every cycle. rise = src & ~src_prev. pending <= (pending & ~clr) | rise.
  - Set wins over a same-cycle W1C clear.
  - A source held high sets pending only once.
- Qualification: active = pending & mask. sel = lowest set index of active. any = |active.
- FSM states: IDLE, ASSERTED, IN_SERVICE. irq is 1 exactly when state==ASSERTED.
- IDLE → ASSERTED when any (1-cycle latency from pending set to irq).
- ASSERTED → IN_SERVICE on a CLAIM read while any:
  - rdata = {1'b1, 26'b0, sel[4:0]}.
  - pending[sel] cleared at that edge.
  - in_service_id <= sel.
- ASSERTED → IDLE when any drops, via mask write or W1C, with no claim.
- CLAIM read in IDLE or IN_SERVICE returns 32'h0 (bit31=0 means nothing to claim) and has no side effect.
- IN_SERVICE → IDLE on a CLAIM write with wdata[4:0]==in_service_id. A mismatched EOI is ignored.
- IN_SERVICE: irq stays 0 and new edges keep accumulating in pending. On return to IDLE, irq re-asserts the next cycle if any.
- Simultaneous MemRead and MemWrite to the same register: the write takes effect, and the read returns the pre-write value.
- Strobes with addr_hit=0 are ignored. Writes to bits ≥ N_SRC are ignored; those bits read 0.

Optional Feature:
INTR_NEST_EN.
- Defined:
  - in_service is an N_SRC-bit vector instead of a single ID.
  - irq asserts whenever sel has strictly higher priority (lower index) than every set in_service bit.
  - A claim sets in_service[sel]; EOI clears in_service[wdata[4:0]] if set.
  - State leaves IN_SERVICE only when the vector is 0. This allows preemption.
- Undefined: the single-level behaviour above; no irq while in service.

Decomposition:
- Package intr_ctrl_pkg: register offsets (OFF_PENDING=0, OFF_MASK=4, OFF_CLAIM=8), CLAIM_VALID_BIT=31, and the state encoding IDLE=2'd0, ASSERTED=2'd1, IN_SERVICE=2'd2.
- Sub-module intr_prio_enc: parameterized lowest-index-first priority encoder (in: N_SRC vector; out: any, 5-bit index). Used for sel, and also in-service comparison when INTR_NEST_EN is defined.

Test Plan:
- Reset, then write MASK=4'b1111, pulse src[2] for 1 cycle → pending=4'b0100 next cycle; irq=1 one cycle later; CLAIM read returns 32'h80000002; pending=0; irq=0.
- src[3] and src[1] rise in the same cycle with mask=4'b1111 → CLAIM returns 32'h80000001. After EOI with wdata=1, irq re-asserts and the next CLAIM returns 32'h80000003.
- Mask=0, pulse src[0] → pending=1 and irq stays 0. Write MASK=1 → irq=1 on the following cycle. Write PENDING=1 (W1C) before claim → irq drops, state returns to IDLE.
- In IN_SERVICE with id 2, write EOI wdata=1 → ignored, irq stays 0. Then EOI wdata=2 → IDLE.
- Same-cycle rising edge on src[0] and W1C of bit 0 → pending[0]=1. CLAIM read in IDLE → 32'h0. Reset asserted mid-ASSERTED → irq=0 immediately and all registers cleared.
- INTR_NEST_EN: claim src[2]; then src[0] rises → irq=1, CLAIM returns 32'h80000000. A rise on src[3] while 2 is in service → no irq until both EOIs complete.
